// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller between the PC register and instruction memory.
// Issues fetches, absorbs memory wait states, decode stalls and branch redirects.
module if_fetch_ctrl #(
    parameter int unsigned         PC_W      = 16,
    parameter int unsigned         INSTR_W   = 32,
    parameter int unsigned         PC_INC    = 4,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_new,
    output logic               pc_write_zero,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               id_stall,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc
);

    localparam logic [PC_W-1:0] PcInc = PC_W'(PC_INC);

    typedef enum logic [1:0] {StBoot, StFetch, StHold, StRedirect} state_e;

    state_e state_q, state_d;

    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]    if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [PC_W-1:0]    hold_pc_q, hold_pc_d;

    logic redirect;
    logic fetch_ack;

    // Branches are ignored in BOOT and while reset is asserted.
    assign redirect  = branch_taken && !reset && (state_q != StBoot);
    assign fetch_ack = imem_ack && !reset && (state_q == StFetch);

    // State and IF/ID registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StBoot;
            if_valid_q   <= 1'b0;
            if_instr_q   <= NOP_INSTR;
            if_pc_q      <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                if (branch_taken) begin
                    state_d = StRedirect;
                end else if (imem_ack && id_stall && if_valid_q) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (branch_taken) begin
                    state_d = StRedirect;
                end else if (!id_stall) begin
                    state_d = StFetch;
                end
            end
            StRedirect: state_d = branch_taken ? StRedirect : StFetch;
        endcase
    end

    // Memory and PC-register outputs
    always_comb begin
        imem_req      = !reset && (state_q == StFetch);
        imem_addr     = pc;
        pc_new        = redirect ? branch_target : pc + PcInc;
        pc_write_zero = !(redirect || fetch_ack);
    end

    // IF/ID and hold-buffer next values
    always_comb begin
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        // Decode drains IF/ID every unstalled edge; a load below overrides this.
        if (!id_stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        unique case (state_q)
            StBoot: ;
            StFetch: begin
                if (branch_taken) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end else if (imem_ack) begin
                    if (!id_stall || !if_valid_q) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pc;
                    end
                end
            end
            StHold: begin
                if (branch_taken) begin
                    if_valid_d   = 1'b0;
                    if_instr_d   = NOP_INSTR;
                    hold_instr_d = '0;
                    hold_pc_d    = '0;
                end else if (!id_stall) begin
                    if_valid_d = 1'b1;
                    if_instr_d = hold_instr_q;
                    if_pc_d    = hold_pc_q;
                end
            end
            StRedirect: begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
        endcase
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: PC register and wait-state memory models plus
// an in-order scoreboard of fetched instructions consumed by decode.
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_r;
    logic [15:0] pc_new;
    logic        pc_write_zero;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;

    logic        pc_set_en;
    logic [15:0] pc_set_val;
    int          mem_wait;
    int          wait_cnt = 0;

    int tests_run = 0;
    int fails     = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
    } item_t;

    item_t sb_q[$];
    item_t exp_it;
    item_t new_it;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc_r),
        .pc_new        (pc_new),
        .pc_write_zero (pc_write_zero),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_stall      (id_stall),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    function automatic logic [31:0] instr_for(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // PC register
    always @(posedge clk) begin
        if (pc_set_en) pc_r <= pc_set_val;
        else if (!pc_write_zero) pc_r <= pc_new;
    end

    // Memory: acks after mem_wait cycles of continuous request
    always_comb imem_ack = imem_req && (wait_cnt >= mem_wait);
    always_comb imem_rdata = instr_for(imem_addr);
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic sb_monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
            end else begin
                if (imem_req) begin
                    tests_run++;
                    if (imem_addr !== pc_r) begin
                        fails++;
                        $display("FAIL addr_eq_pc: imem_addr=%h pc=%h", imem_addr, pc_r);
                    end
                end
                if (if_valid && !id_stall) begin
                    tests_run++;
                    if (sb_q.size() == 0) begin
                        fails++;
                        $display("FAIL sb_unexpected: if_pc=%h if_instr=%h, none expected",
                                 if_pc, if_instr);
                    end else begin
                        exp_it = sb_q.pop_front();
                        if (if_instr !== exp_it.instr || if_pc !== exp_it.pc) begin
                            fails++;
                            $display("FAIL sb_instr: got pc=%h instr=%h, want pc=%h instr=%h",
                                     if_pc, if_instr, exp_it.pc, exp_it.instr);
                        end
                    end
                end
                if (branch_taken) sb_q.delete();
                if (imem_req && imem_ack && !branch_taken) begin
                    new_it.instr = instr_for(pc_r);
                    new_it.pc    = pc_r;
                    sb_q.push_back(new_it);
                end
            end
        end
    endtask

    // Leaves the bench in the BOOT cycle, 1 ns after the edge
    task automatic start(input logic [15:0] pc0);
        @(posedge clk); #1;
        reset = 1'b1; pc_set_en = 1'b1; pc_set_val = pc0;
        id_stall = 1'b0; branch_taken = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; pc_set_en = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1; pc_set_en = 1'b1; pc_set_val = 16'h0100;
        branch_taken = 1'b1; branch_target = 16'h0800;
        @(posedge clk); #1;
        pc_set_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || pc_write_zero !== 1'b1) begin
            fails++;
            $display("FAIL rst_req: req=%b pwz=%b, want 0 1", imem_req, pc_write_zero);
        end
        tests_run++;
        if (pc_new !== 16'h0104) begin
            fails++;
            $display("FAIL rst_pc_new: got %h want 0104", pc_new);
        end
        tests_run++;
        if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 16'h0) begin
            fails++;
            $display("FAIL rst_ifid: v=%b instr=%h pc=%h, want 0 %h 0000",
                     if_valid, if_instr, if_pc, NOP);
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_zero_wait();
        mem_wait = 0;
        start(16'h0000);
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || pc_write_zero !== 1'b1) begin
            fails++;
            $display("FAIL boot: req=%b pwz=%b, want 0 1", imem_req, pc_write_zero);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(4 * k) || pc_write_zero !== 1'b0) begin
                fails++;
                $display("FAIL zw_fetch%0d: req=%b addr=%h pwz=%b, want 1 %h 0",
                         k, imem_req, imem_addr, pc_write_zero, 16'(4 * k));
            end
            if (k > 0) begin
                tests_run++;
                if (if_valid !== 1'b1 || if_pc !== 16'(4 * (k - 1))) begin
                    fails++;
                    $display("FAIL zw_ifid%0d: v=%b pc=%h, want 1 %h",
                             k, if_valid, if_pc, 16'(4 * (k - 1)));
                end
            end
        end
    endtask

    task automatic test_wait_states();
        mem_wait = 2;
        start(16'h0010);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0010 ||
                pc_write_zero !== (c < 2)) begin
                fails++;
                $display("FAIL ws_cycle%0d: req=%b addr=%h pwz=%b, want 1 0010 %b",
                         c, imem_req, imem_addr, pc_write_zero, (c < 2));
            end
        end
        @(negedge clk);
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0010 || imem_addr !== 16'h0014) begin
            fails++;
            $display("FAIL ws_capture: v=%b if_pc=%h addr=%h, want 1 0010 0014",
                     if_valid, if_pc, imem_addr);
        end
    endtask

    task automatic test_stall_hold();
        mem_wait = 0;
        start(16'h001C);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        id_stall = 1'b1;
        @(negedge clk);
        tests_run++;
        if (if_valid !== 1'b1 || imem_addr !== 16'h0020 || imem_ack !== 1'b1) begin
            fails++;
            $display("FAIL st_ack: v=%b addr=%h ack=%b, want 1 0020 1",
                     if_valid, imem_addr, imem_ack);
        end
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            tests_run++;
            if (imem_req !== 1'b0 || pc_r !== 16'h0024 || if_pc !== 16'h001C) begin
                fails++;
                $display("FAIL st_hold%0d: req=%b pc=%h if_pc=%h, want 0 0024 001c",
                         h, imem_req, pc_r, if_pc);
            end
        end
        @(posedge clk); #1;
        id_stall = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || pc_write_zero !== 1'b1) begin
            fails++;
            $display("FAIL st_release: req=%b pwz=%b, want 0 1", imem_req, pc_write_zero);
        end
        @(negedge clk);
        tests_run++;
        if (if_instr !== instr_for(16'h0020) || if_pc !== 16'h0020 ||
            imem_req !== 1'b1 || imem_addr !== 16'h0024) begin
            fails++;
            $display("FAIL st_drain: instr=%h pc=%h req=%b addr=%h, want %h 0020 1 0024",
                     if_instr, if_pc, imem_req, imem_addr, instr_for(16'h0020));
        end
    endtask

    task automatic test_branch_wait();
        bit found;
        mem_wait = 3;
        start(16'h0040);
        @(negedge clk);
        @(posedge clk); #1;
        branch_taken = 1'b1; branch_target = 16'h0100;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_ack !== 1'b0 || pc_write_zero !== 1'b0 ||
            pc_new !== 16'h0100) begin
            fails++;
            $display("FAIL bw_branch: req=%b ack=%b pwz=%b pc_new=%h, want 1 0 0 0100",
                     imem_req, imem_ack, pc_write_zero, pc_new);
        end
        @(posedge clk); #1;
        branch_taken = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL bw_redirect: req=%b v=%b, want 0 0", imem_req, if_valid);
        end
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
            fails++;
            $display("FAIL bw_refetch: req=%b addr=%h, want 1 0100", imem_req, imem_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (if_valid) found = 1'b1;
        end
        tests_run++;
        if (!found || if_pc !== 16'h0100) begin
            fails++;
            $display("FAIL bw_target: found=%b if_pc=%h, want 1 0100", found, if_pc);
        end
    endtask

    task automatic test_branch_ack();
        mem_wait = 0;
        start(16'h0050);
        @(negedge clk);
        @(posedge clk); #1;
        branch_taken = 1'b1; branch_target = 16'h0200;
        @(negedge clk);
        tests_run++;
        if (imem_ack !== 1'b1 || pc_write_zero !== 1'b0 || pc_new !== 16'h0200) begin
            fails++;
            $display("FAIL ba_branch: ack=%b pwz=%b pc_new=%h, want 1 0 0200",
                     imem_ack, pc_write_zero, pc_new);
        end
        @(posedge clk); #1;
        branch_taken = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL ba_redirect: req=%b v=%b, want 0 0", imem_req, if_valid);
        end
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin
            fails++;
            $display("FAIL ba_refetch: req=%b addr=%h, want 1 0200", imem_req, imem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0200) begin
            fails++;
            $display("FAIL ba_target: v=%b if_pc=%h, want 1 0200", if_valid, if_pc);
        end
    endtask

    task automatic test_back_to_back_branch();
        mem_wait = 0;
        start(16'h0070);
        @(negedge clk);
        @(posedge clk); #1;
        branch_taken = 1'b1; branch_target = 16'h0300;
        @(negedge clk);
        @(posedge clk); #1;
        branch_target = 16'h0340;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || pc_write_zero !== 1'b0 || pc_new !== 16'h0340) begin
            fails++;
            $display("FAIL bb_rebranch: req=%b pwz=%b pc_new=%h, want 0 0 0340",
                     imem_req, pc_write_zero, pc_new);
        end
        @(posedge clk); #1;
        branch_taken = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL bb_redirect2: req=%b v=%b, want 0 0", imem_req, if_valid);
        end
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0340) begin
            fails++;
            $display("FAIL bb_refetch: req=%b addr=%h, want 1 0340", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_hold();
        mem_wait = 0;
        start(16'h0060);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        id_stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL rh_hold: req=%b, want 0", imem_req);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || pc_write_zero !== 1'b1 || pc_new !== 16'h006C) begin
            fails++;
            $display("FAIL rh_reset: req=%b pwz=%b pc_new=%h, want 0 1 006c",
                     imem_req, pc_write_zero, pc_new);
        end
        @(posedge clk); #1;
        reset = 1'b0; id_stall = 1'b0;
        @(negedge clk);
        tests_run++;
        if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 16'h0 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL rh_boot: v=%b instr=%h pc=%h req=%b, want 0 %h 0000 0",
                     if_valid, if_instr, if_pc, imem_req, NOP);
        end
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0068) begin
            fails++;
            $display("FAIL rh_resume: req=%b addr=%h, want 1 0068", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        mem_wait = 0;
        start(16'hFFF8);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (pc_new !== 16'hFFFC) begin
            fails++;
            $display("FAIL wr_fff8: pc_new=%h, want fffc", pc_new);
        end
        @(negedge clk);
        tests_run++;
        if (pc_new !== 16'h0000 || pc_write_zero !== 1'b0 || imem_addr !== 16'hFFFC) begin
            fails++;
            $display("FAIL wr_fffc: pc_new=%h pwz=%b addr=%h, want 0000 0 fffc",
                     pc_new, pc_write_zero, imem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (imem_addr !== 16'h0000 || if_pc !== 16'hFFFC) begin
            fails++;
            $display("FAIL wr_next: addr=%h if_pc=%h, want 0000 fffc", imem_addr, if_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; id_stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        pc_set_en = 1'b1; pc_set_val = '0; mem_wait = 0;
        fork
            sb_monitor();
        join_none
        repeat (2) @(posedge clk);
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_branch_wait();
        test_branch_ack();
        test_back_to_back_branch();
        test_reset_in_hold();
        test_wrap();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller that sits between the PC register and instruction memory. It reads the current pc, issues the fetch request, and captures the returned instruction into the IF/ID register. It drives pc_new and pc_write_zero back into the PC register. It also absorbs memory wait states, decode stalls and branch redirects.

Parameters:
PC_W, 16, program counter width
INSTR_W, 32, instruction width
PC_INC, 4, sequential PC increment
NOP_INSTR, 32'h00000013, value driven on if_instr when if_valid=0

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
pc  in  PC_W  current PC from the PC register
pc_new  out  PC_W  next PC to the PC register
pc_write_zero  out  1  1 = PC register holds its value this cycle
imem_req  out  1  fetch request, level-sensitive
imem_addr  out  PC_W  fetch address; equals pc whenever imem_req=1
imem_ack  in  1  instruction memory has accepted and returned data this cycle
imem_rdata  in  INSTR_W  instruction data; valid only when imem_ack=1
branch_taken  in  1  redirect request from EX; single-cycle pulse
branch_target  in  PC_W  redirect address
id_stall  in  1  decode cannot accept a new instruction this cycle
if_valid  out  1  IF/ID register holds a valid instruction
if_instr  out  INSTR_W  IF/ID instruction
if_pc  out  PC_W  PC of if_instr

Behaviour:
- Reset is synchronous and active-high. While reset=1 at posedge, all of the following load:
  - state=BOOT
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0
  - hold buffer cleared
- Combinational outputs during reset: imem_req=0, pc_write_zero=1, pc_new=pc+PC_INC.
- Reset mid-operation abandons any outstanding fetch. The memory sees imem_req drop.
- Memory protocol:
  - imem_req is a level signal.
  - imem_addr is held stable until the cycle imem_ack=1.
  - The ack cycle completes the transfer.
  - Dropping imem_req before ack cancels the access, and the memory ignores it.
- pc_new mux: branch_taken ? branch_target : pc+PC_INC. Addition is modulo 2^PC_W; 16'hFFFC+4 wraps to 0.
- pc_write_zero is 0 only in these cases:
  - branch_taken=1 (any state except BOOT/reset)
  - FETCH with imem_ack=1
  - In all other cycles it is 1.
- IF/ID consumption: when id_stall=0, decode consumes the IF/ID contents at each posedge. If nothing new loads, if_valid<=0 and if_instr<=NOP_INSTR.
- State machine:
  - BOOT: imem_req=0. Next state is FETCH. Gives the PC register one cycle after reset.
  - FETCH: imem_req=1, imem_addr=pc.
    - branch_taken=1 has priority. Any same-cycle ack data is discarded. PC loads branch_target, if_valid<=0, next state is REDIRECT.
    - Else, imem_ack=1 and (id_stall=0 or if_valid=0): IF/ID loads {1, imem_rdata, pc}. PC advances. Stay in FETCH.
    - Else, imem_ack=1 and id_stall=1 and if_valid=1: hold buffer loads {imem_rdata, pc}. PC advances. Next state is HOLD.
    - Else (no ack): stay in FETCH; PC is held.
  - HOLD: imem_req=0, PC is held.
    - branch_taken=1: buffer is dropped, if_valid<=0, PC loads target, next state is REDIRECT.
    - Else, id_stall=0: IF/ID loads from the buffer with if_valid=1. Next state is FETCH.
    - Else: stay in HOLD; IF/ID is unchanged.
  - REDIRECT: imem_req=0 for exactly one cycle, which cancels the stale access. if_valid<=0. Next state is FETCH.
    - A branch_taken arriving in REDIRECT loads the new target, and the state stays REDIRECT for one more cycle.
- Stall behaviour: while id_stall=1 and the state is not completing a load, IF/ID holds its contents unchanged.
- Latency:
  - From the ack cycle to if_valid=1 is 1 cycle.
  - From branch_taken to the first request at the target is 2 cycles (REDIRECT, then FETCH).
- Throughput: one instruction per cycle with zero-wait memory and no stalls.
- The PC register never advances without a captured instruction. Every PC value is therefore fetched exactly once unless it is flushed.

Test Plan:
- Reset then zero-wait memory, imem_ack tied to 1, pc starts at 0 -> BOOT 1 cycle; imem_addr 0,4,8,…; if_pc trails by 1 cycle; if_valid=1 continuously from cycle 2; pc_write_zero=0 every FETCH cycle.
- Two wait states per fetch at pc=0x0010 -> imem_req high for 3 cycles with addr stable at 0x0010; pc_write_zero=1 for 2 cycles then 0; if_pc=0x0010 one cycle after ack.
- id_stall=1 held 3 cycles while an ack returns for pc=0x0020 with if_valid=1 -> HOLD entered; pc already 0x0024; imem_req=0 during HOLD; when the stall drops, if_instr becomes the 0x0020 data; next fetch is at 0x0024.
- branch_taken with target 0x0100 during a FETCH wait state at 0x0040 -> imem_req drops for 1 REDIRECT cycle; if_valid=0; next request at 0x0100; no instruction from 0x0040 ever appears.
- branch_taken in the same cycle as imem_ack at 0x0050 with target 0x0200 -> ack data discarded; pc_new=0x0200; if_valid=0; next request at 0x0200.
- reset asserted while in HOLD with an outstanding request -> next cycle if_valid=0, if_instr=0x00000013, imem_req=0, state BOOT; pc wrap test: fetch at 0xFFFC gives pc_new=0x0000.
